// File: rtl/load_store_unit_if.sv
// Request/response channel from the pipeline plus the data-memory port of the load/store unit.
// Handshake: a request transfers on a rising edge where reqValid && reqReady; the requester
// holds all req* fields stable while reqValid=1 and reqReady=0. respValid is a one-cycle pulse
// with no back-pressure.
interface load_store_unit_if #(
  parameter int ADDR_SIZE = 32,
  parameter int WORD_LEN  = 32
);
  logic                 reqValid;
  logic                 reqReady;
  logic                 reqWrite;
  logic [2:0]           reqFunct3;
  logic [ADDR_SIZE-1:0] reqAddr;
  logic [WORD_LEN-1:0]  reqWData;
  logic                 respValid;
  logic [WORD_LEN-1:0]  respRData;
  logic                 memWriteEnable;
  logic [ADDR_SIZE-1:0] memAddr;
  logic [2:0]           memUnitSize;
  logic [WORD_LEN-1:0]  memWriteData;
  logic [WORD_LEN-1:0]  memReadData;

  modport master (
    output reqValid, reqWrite, reqFunct3, reqAddr, reqWData, memReadData,
    input  reqReady, respValid, respRData, memWriteEnable, memAddr, memUnitSize, memWriteData
  );

  modport slave (
    input  reqValid, reqWrite, reqFunct3, reqAddr, reqWData, memReadData,
    output reqReady, respValid, respRData, memWriteEnable, memAddr, memUnitSize, memWriteData
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, misaligned accesses split into aligned memory cycles,
// loads always read whole words and are extracted/extended locally.
module load_store_unit #(
  parameter int ADDR_SIZE = 32,
  parameter int WORD_LEN  = 32
) (
  input  logic              clk,
  input  logic              rstn,
  load_store_unit_if.slave  bus,
  output logic [2:0]        fsm_state
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LD0  = 3'd1;
  localparam logic [2:0] S_LD1  = 3'd2;
  localparam logic [2:0] S_ST   = 3'd3;
  localparam logic [2:0] S_RESP = 3'd4;

  localparam int DW_IDX = $clog2(2 * WORD_LEN);
  localparam int W_IDX  = $clog2(WORD_LEN);

  logic [2:0]           state;
  logic [ADDR_SIZE-1:0] addr_q;
  logic [WORD_LEN-1:0]  wdata_q;
  logic [2:0]           funct3_q;
  logic                 write_q;
  logic [WORD_LEN-1:0]  word0_q;
  logic [1:0]           byte_cnt;
  logic [WORD_LEN-1:0]  rdata_q;

  logic [1:0]           size_code;
  logic [2:0]           nbytes;
  logic [1:0]           offset;
  logic                 misaligned;
  logic                 crossing;
  logic                 last_byte;
  logic                 accept;
  logic [ADDR_SIZE-1:0] base_addr;
  logic [ADDR_SIZE-1:0] next_addr;
  logic [2*WORD_LEN-1:0] load_dword;
  logic [DW_IDX-1:0]    ld_shift;
  logic [WORD_LEN-1:0]  raw;
  logic [WORD_LEN-1:0]  load_result;
  logic                 sign_ext;
  logic [7:0]           st_byte;

  // Undefined size encoding (11) behaves as a word access.
  assign size_code  = (funct3_q[1:0] == 2'b11) ? 2'b10 : funct3_q[1:0];
  assign nbytes     = (size_code == 2'b00) ? 3'd1 : (size_code == 2'b01) ? 3'd2 : 3'd4;
  assign offset     = addr_q[1:0];
  assign misaligned = ((size_code == 2'b01) && addr_q[0]) ||
                      ((size_code == 2'b10) && (addr_q[1:0] != 2'b00));
  assign crossing   = (({1'b0, offset} + nbytes) > 3'd4);
  assign last_byte  = ({1'b0, byte_cnt} == (nbytes - 3'd1));
  assign base_addr  = {addr_q[ADDR_SIZE-1:2], 2'b00};
  assign next_addr  = base_addr + ADDR_SIZE'(4);
  assign sign_ext   = ~funct3_q[2];

  // In LD1 the second word sits above the captured first word, forming a little-endian window.
  assign load_dword = (state == S_LD1) ? {bus.memReadData, word0_q}
                                       : {{WORD_LEN{1'b0}}, bus.memReadData};
  assign ld_shift   = DW_IDX'({offset, 3'b000});
  assign raw        = load_dword[ld_shift +: WORD_LEN];

  always_comb begin
    load_result = raw;
    case (size_code)
      2'b00:   load_result = {{(WORD_LEN-8){sign_ext & raw[7]}}, raw[7:0]};
      2'b01:   load_result = {{(WORD_LEN-16){sign_ext & raw[15]}}, raw[15:0]};
      default: load_result = raw;
    endcase
  end

  assign st_byte = wdata_q[W_IDX'({byte_cnt, 3'b000}) +: 8];

  assign bus.reqReady  = (state == S_IDLE) || (state == S_RESP);
  assign bus.respValid = (state == S_RESP);
  assign bus.respRData = rdata_q;
  assign accept        = bus.reqValid && bus.reqReady;
  assign fsm_state     = state;

  always_comb begin
    bus.memWriteEnable = 1'b0;
    bus.memAddr        = '0;
    bus.memUnitSize    = 3'b010;
    bus.memWriteData   = '0;
    case (state)
      S_LD0: bus.memAddr = base_addr;
      S_LD1: bus.memAddr = next_addr;
      S_ST: begin
        bus.memWriteEnable = 1'b1;
        if (misaligned) begin
          bus.memAddr      = addr_q + ADDR_SIZE'(byte_cnt);
          bus.memUnitSize  = 3'b000;
          bus.memWriteData = {{(WORD_LEN-8){1'b0}}, st_byte};
        end else begin
          bus.memAddr      = addr_q;
          bus.memUnitSize  = {1'b0, size_code};
          bus.memWriteData = wdata_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= S_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      funct3_q <= 3'b010;
      write_q  <= 1'b0;
      word0_q  <= '0;
      byte_cnt <= 2'd0;
      rdata_q  <= '0;
    end else begin
      case (state)
        S_IDLE, S_RESP: begin
          if (accept) begin
            addr_q   <= bus.reqAddr;
            wdata_q  <= bus.reqWData;
            funct3_q <= bus.reqFunct3;
            write_q  <= bus.reqWrite;
            byte_cnt <= 2'd0;
            state    <= bus.reqWrite ? S_ST : S_LD0;
          end else begin
            state <= S_IDLE;
          end
        end
        S_LD0: begin
          word0_q <= bus.memReadData;
          if (crossing) begin
            state <= S_LD1;
          end else begin
            rdata_q <= load_result;
            state   <= S_RESP;
          end
        end
        S_LD1: begin
          rdata_q <= load_result;
          state   <= S_RESP;
        end
        S_ST: begin
          if (!misaligned || last_byte) begin
            rdata_q  <= '0;
            byte_cnt <= 2'd0;
            state    <= S_RESP;
          end else begin
            byte_cnt <= byte_cnt + 2'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // write_q is kept for debug visibility of the in-flight request type.
  logic unused_write;
  assign unused_write = write_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a 64-word memory model answers the data port and
// each scenario task checks cycle traces, results and final memory contents.
module tb_load_store_unit;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  load_store_unit_if #(.ADDR_SIZE(32), .WORD_LEN(32)) bus ();
  logic [2:0] fsm_state;

  load_store_unit #(.ADDR_SIZE(32), .WORD_LEN(32)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .bus       (bus),
    .fsm_state (fsm_state)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // Memory model: word-indexed by addr[7:2], honours byte/half/word write sizes.
  logic [31:0] mem [64];
  logic        pl_en = 1'b0;
  logic [5:0]  pl_idx = '0;
  logic [31:0] pl_data = '0;

  assign bus.memReadData = mem[bus.memAddr[7:2]];

  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_data;
    else if (bus.memWriteEnable) begin
      case (bus.memUnitSize[1:0])
        2'b00:   mem[bus.memAddr[7:2]][{bus.memAddr[1:0], 3'b000} +: 8] <= bus.memWriteData[7:0];
        2'b01:   mem[bus.memAddr[7:2]][{bus.memAddr[1], 4'b0000} +: 16] <= bus.memWriteData[15:0];
        default: mem[bus.memAddr[7:2]] <= bus.memWriteData;
      endcase
    end
  end

  // Per-request trace of memory cycles between accept and response.
  logic [31:0] tr_addr [8];
  logic [2:0]  tr_size [8];
  logic        tr_we   [8];
  logic [31:0] tr_wd   [8];
  int          n_cyc;
  logic [31:0] resp_data;
  logic [39:0] exp_q [$];

  task automatic preload(input logic [31:0] byte_addr, input logic [31:0] data);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = byte_addr[7:2]; pl_data = data;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic present(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    bus.reqValid = 1'b1; bus.reqWrite = w; bus.reqFunct3 = f3; bus.reqAddr = a; bus.reqWData = d;
  endtask

  // Accept on the next edge, then log every memory cycle until respValid (bounded).
  task automatic finish_req();
    @(posedge clk); #1;
    bus.reqValid = 1'b0;
    n_cyc = 0;
    resp_data = 'x;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.respValid) begin
        resp_data = bus.respRData;
        break;
      end
      if (n_cyc < 8) begin
        tr_addr[n_cyc] = bus.memAddr; tr_size[n_cyc] = bus.memUnitSize;
        tr_we[n_cyc] = bus.memWriteEnable; tr_wd[n_cyc] = bus.memWriteData;
      end
      n_cyc++;
    end
  endtask

  task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    present(w, f3, a, d);
    finish_req();
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests_run++; if (bus.reqReady !== 1'b1) begin tests_failed++; $display("FAIL rst_ready: got %b want 1", bus.reqReady); end
    tests_run++; if (bus.respValid !== 1'b0) begin tests_failed++; $display("FAIL rst_resp_valid: got %b want 0", bus.respValid); end
    tests_run++; if (bus.respRData !== 32'h0) begin tests_failed++; $display("FAIL rst_rdata: got %h want 0", bus.respRData); end
    tests_run++; if (bus.memWriteEnable !== 1'b0) begin tests_failed++; $display("FAIL rst_we: got %b want 0", bus.memWriteEnable); end
    tests_run++; if (bus.memAddr !== 32'h0) begin tests_failed++; $display("FAIL rst_addr: got %h want 0", bus.memAddr); end
    tests_run++; if (bus.memUnitSize !== 3'b010) begin tests_failed++; $display("FAIL rst_size: got %b want 010", bus.memUnitSize); end
    tests_run++; if (bus.memWriteData !== 32'h0) begin tests_failed++; $display("FAIL rst_wdata: got %h want 0", bus.memWriteData); end
    tests_run++; if (fsm_state !== 3'd0) begin tests_failed++; $display("FAIL rst_state: got %0d want 0", fsm_state); end
  endtask

  task automatic test_aligned_load();
    preload(32'h10, 32'h80FF1234);
    issue(1'b0, 3'b010, 32'h10, 32'h0);
    tests_run++; if (n_cyc !== 1) begin tests_failed++; $display("FAIL lw_cycles: got %0d want 1", n_cyc); end
    tests_run++; if (tr_addr[0] !== 32'h10) begin tests_failed++; $display("FAIL lw_addr: got %h want 00000010", tr_addr[0]); end
    tests_run++; if (tr_size[0] !== 3'b010) begin tests_failed++; $display("FAIL lw_size: got %b want 010", tr_size[0]); end
    tests_run++; if (tr_we[0] !== 1'b0) begin tests_failed++; $display("FAIL lw_we: got %b want 0", tr_we[0]); end
    tests_run++; if (resp_data !== 32'h80FF1234) begin tests_failed++; $display("FAIL lw_data: got %h want 80ff1234", resp_data); end
  endtask

  task automatic test_byte_ext();
    issue(1'b0, 3'b000, 32'h13, 32'h0);
    tests_run++; if (tr_addr[0] !== 32'h10) begin tests_failed++; $display("FAIL lb_addr: got %h want 00000010", tr_addr[0]); end
    tests_run++; if (resp_data !== 32'hFFFFFF80) begin tests_failed++; $display("FAIL lb_data: got %h want ffffff80", resp_data); end
    issue(1'b0, 3'b100, 32'h13, 32'h0);
    tests_run++; if (resp_data !== 32'h00000080) begin tests_failed++; $display("FAIL lbu_data: got %h want 00000080", resp_data); end
    issue(1'b0, 3'b101, 32'h12, 32'h0);
    tests_run++; if (resp_data !== 32'h000080FF) begin tests_failed++; $display("FAIL lhu_data: got %h want 000080ff", resp_data); end
    issue(1'b0, 3'b001, 32'h12, 32'h0);
    tests_run++; if (resp_data !== 32'hFFFF80FF) begin tests_failed++; $display("FAIL lh_data: got %h want ffff80ff", resp_data); end
    tests_run++; if (n_cyc !== 1) begin tests_failed++; $display("FAIL lh_cycles: got %0d want 1", n_cyc); end
  endtask

  task automatic test_crossing_load();
    preload(32'h0C, 32'h44332211);
    preload(32'h10, 32'h88776655);
    issue(1'b0, 3'b010, 32'h0E, 32'h0);
    tests_run++; if (n_cyc !== 2) begin tests_failed++; $display("FAIL xlw_cycles: got %0d want 2", n_cyc); end
    tests_run++; if (tr_addr[0] !== 32'h0C) begin tests_failed++; $display("FAIL xlw_addr0: got %h want 0000000c", tr_addr[0]); end
    tests_run++; if (tr_addr[1] !== 32'h10) begin tests_failed++; $display("FAIL xlw_addr1: got %h want 00000010", tr_addr[1]); end
    tests_run++; if (tr_size[1] !== 3'b010 || tr_we[1] !== 1'b0) begin tests_failed++; $display("FAIL xlw_ctl1: got size %b we %b want 010 0", tr_size[1], tr_we[1]); end
    tests_run++; if (resp_data !== 32'h66554433) begin tests_failed++; $display("FAIL xlw_data: got %h want 66554433", resp_data); end
    issue(1'b0, 3'b001, 32'h0F, 32'h0);
    tests_run++; if (n_cyc !== 2) begin tests_failed++; $display("FAIL xlh_cycles: got %0d want 2", n_cyc); end
    tests_run++; if (resp_data !== 32'h00005544) begin tests_failed++; $display("FAIL xlh_data: got %h want 00005544", resp_data); end
  endtask

  task automatic test_wrap_load();
    preload(32'hFFFFFFFC, 32'hDDCCBBAA);
    preload(32'h00000000, 32'h44332211);
    issue(1'b0, 3'b010, 32'hFFFFFFFE, 32'h0);
    tests_run++; if (tr_addr[0] !== 32'hFFFFFFFC) begin tests_failed++; $display("FAIL wrap_addr0: got %h want fffffffc", tr_addr[0]); end
    tests_run++; if (tr_addr[1] !== 32'h00000000) begin tests_failed++; $display("FAIL wrap_addr1: got %h want 00000000", tr_addr[1]); end
    tests_run++; if (resp_data !== 32'h2211DDCC) begin tests_failed++; $display("FAIL wrap_data: got %h want 2211ddcc", resp_data); end
  endtask

  task automatic test_misaligned_store();
    logic [39:0] e;
    preload(32'h08, 32'h11111111);
    preload(32'h0C, 32'h22222222);
    exp_q.push_back({32'h0B, 8'hDD});
    exp_q.push_back({32'h0C, 8'hCC});
    exp_q.push_back({32'h0D, 8'hBB});
    exp_q.push_back({32'h0E, 8'hAA});
    issue(1'b1, 3'b010, 32'h0B, 32'hAABBCCDD);
    tests_run++; if (n_cyc !== 4) begin tests_failed++; $display("FAIL msw_cycles: got %0d want 4", n_cyc); end
    for (int k = 0; k < 4; k++) begin
      e = exp_q.pop_front();
      tests_run++; if (tr_addr[k] !== e[39:8] || tr_wd[k] !== {24'h0, e[7:0]} || tr_size[k] !== 3'b000 || tr_we[k] !== 1'b1) begin
        tests_failed++; $display("FAIL msw_byte%0d: got addr %h data %h size %b we %b want addr %h data %h size 000 we 1", k, tr_addr[k], tr_wd[k], tr_size[k], tr_we[k], e[39:8], {24'h0, e[7:0]});
      end
    end
    tests_run++; if (resp_data !== 32'h0) begin tests_failed++; $display("FAIL msw_rdata: got %h want 0", resp_data); end
    tests_run++; if (mem[2] !== 32'hDD111111) begin tests_failed++; $display("FAIL msw_word08: got %h want dd111111", mem[2]); end
    tests_run++; if (mem[3] !== 32'h22AABBCC) begin tests_failed++; $display("FAIL msw_word0c: got %h want 22aabbcc", mem[3]); end
    issue(1'b0, 3'b010, 32'h0C, 32'h0);
    tests_run++; if (resp_data !== 32'h22AABBCC) begin tests_failed++; $display("FAIL msw_readback: got %h want 22aabbcc", resp_data); end
  endtask

  task automatic test_back_to_back();
    preload(32'h20, 32'h5555AAAA);
    issue(1'b1, 3'b001, 32'h20, 32'hFFFF1234);
    tests_run++; if (n_cyc !== 1) begin tests_failed++; $display("FAIL sh_cycles: got %0d want 1", n_cyc); end
    tests_run++; if (tr_addr[0] !== 32'h20 || tr_size[0] !== 3'b001 || tr_we[0] !== 1'b1 || tr_wd[0] !== 32'hFFFF1234) begin
      tests_failed++; $display("FAIL sh_cycle: got addr %h size %b we %b data %h want 00000020 001 1 ffff1234", tr_addr[0], tr_size[0], tr_we[0], tr_wd[0]);
    end
    tests_run++; if (resp_data !== 32'h0) begin tests_failed++; $display("FAIL sh_rdata: got %h want 0", resp_data); end
    tests_run++; if (bus.reqReady !== 1'b1) begin tests_failed++; $display("FAIL b2b_ready: got %b want 1", bus.reqReady); end
    present(1'b0, 3'b010, 32'h20, 32'h0);
    finish_req();
    tests_run++; if (n_cyc !== 1) begin tests_failed++; $display("FAIL b2b_cycles: got %0d want 1", n_cyc); end
    tests_run++; if (resp_data !== 32'h55551234) begin tests_failed++; $display("FAIL b2b_data: got %h want 55551234", resp_data); end
  endtask

  task automatic test_reset_mid_store();
    int stray;
    preload(32'h08, 32'h11111111);
    preload(32'h0C, 32'h22222222);
    @(negedge clk);
    present(1'b1, 3'b010, 32'h0B, 32'hAABBCCDD);
    @(posedge clk); #1;
    bus.reqValid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rstn = 1'b0;
    #1;
    tests_run++; if (bus.reqReady !== 1'b1 || bus.respValid !== 1'b0) begin tests_failed++; $display("FAIL mid_rst_hs: got ready %b resp %b want 1 0", bus.reqReady, bus.respValid); end
    tests_run++; if (bus.memWriteEnable !== 1'b0 || bus.memAddr !== 32'h0 || bus.memUnitSize !== 3'b010 || bus.memWriteData !== 32'h0) begin
      tests_failed++; $display("FAIL mid_rst_mem: got we %b addr %h size %b data %h want 0 0 010 0", bus.memWriteEnable, bus.memAddr, bus.memUnitSize, bus.memWriteData);
    end
    stray = 0;
    repeat (3) begin @(negedge clk); if (bus.respValid !== 1'b0) stray++; end
    rstn = 1'b1;
    repeat (4) begin @(negedge clk); if (bus.respValid !== 1'b0 || bus.reqReady !== 1'b1) stray++; end
    tests_run++; if (stray !== 0) begin tests_failed++; $display("FAIL mid_rst_resp: got %0d bad cycles want 0", stray); end
    tests_run++; if (mem[2] !== 32'hDD111111) begin tests_failed++; $display("FAIL mid_rst_word08: got %h want dd111111", mem[2]); end
    tests_run++; if (mem[3] !== 32'h222222CC) begin tests_failed++; $display("FAIL mid_rst_word0c: got %h want 222222cc", mem[3]); end
    issue(1'b0, 3'b010, 32'h0C, 32'h0);
    tests_run++; if (resp_data !== 32'h222222CC) begin tests_failed++; $display("FAIL mid_rst_readback: got %h want 222222cc", resp_data); end
  endtask

  initial begin
    bus.reqValid = 1'b0; bus.reqWrite = 1'b0; bus.reqFunct3 = 3'b010; bus.reqAddr = '0; bus.reqWData = '0;
    rstn = 1'b0;
    test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    test_reset();
    test_aligned_load();
    test_byte_ext();
    test_crossing_load();
    test_wrap_load();
    test_misaligned_store();
    test_back_to_back();
    test_reset_mid_store();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Pipeline-side initiator for the data memory port. Accepts one load or store request at a time via a valid/ready handshake and drives the data-memory interface: addr, writeEnable, unitSize and writeData out, with combinational readData back. Misaligned accesses are split into several aligned memory cycles. Loads are extracted and extended locally, so the memory is only ever read as whole words.

## Interface
- ADDR_SIZE, 32, address width
- WORD_LEN, 32, data width

- clk  in  1  clock, all state on rising edge
- rstn  in  1  asynchronous, active-low reset
- reqValid  in  1  request present
- reqReady  out  1  unit can accept a request this cycle
- reqWrite  in  1  1 = store, 0 = load
- reqFunct3  in  3  000 byte, 001 half, 010 word, 100 byte unsigned, 101 half unsigned
- reqAddr  in  ADDR_SIZE  byte address
- reqWData  in  WORD_LEN  store data, right-aligned
- respValid  out  1  one-cycle completion pulse
- respRData  out  WORD_LEN  load result; 0 for stores
- memWriteEnable  out  1  memory write strobe
- memAddr  out  ADDR_SIZE  memory byte address
- memUnitSize  out  3  memory access size (funct3 encoding)
- memWriteData  out  WORD_LEN  memory write data
- memReadData  in  WORD_LEN  combinational read of the word at memAddr[ADDR_SIZE-1:2]

## Operation
- **Request capture.** A request is accepted on a rising edge when reqValid && reqReady. Address, data, funct3 and write flag are registered.
- **Access size.** Size is 1, 2 or 4 bytes, taken from funct3[1:0]. Undefined funct3 values are treated as a word access. Stores ignore funct3[2].
- **Misalignment.** An access is misaligned when it is a half with addr[0]=1, or a word with addr[1:0]!=0.
- **States:**
  - IDLE.
  - LD0: read the first word at {addr[31:2],00}.
  - LD1: read the next word at {addr[31:2],00}+4, wrapping modulo 2^32.
  - ST: store cycle(s).
  - RESP.
- **Loads:**
  - IDLE → LD0.
  - The word from LD0 is captured. If offset+size > 4, go to LD1, then RESP; otherwise go to RESP.
  - memUnitSize=010 in every load cycle.
  - The bytes are assembled little-endian from the captured words. The result is sign-extended for 000/001 and zero-extended for 100/101.
- **Aligned stores:**
  - One ST cycle with memAddr=addr, memUnitSize=funct3 and memWriteEnable=1.
  - memWriteData=reqWData; the memory uses the low byte or half.
- **Misaligned stores:**
  - ST repeats once per byte, `size` times.
  - Byte k goes to addr+k (wrapping) with memUnitSize=000 and memWriteData={24'b0, wdata[8k+7:8k]}.
  - A byte counter selects the byte.
- **RESP:** respValid=1 for the single cycle.
  - If a request is accepted in RESP, go to LD0 or ST (back-to-back).
  - Otherwise go to IDLE.
- **Handshake outputs.**
  - reqReady = (state==IDLE || state==RESP).
  - respRData holds its value until the next response.
- **Memory outputs outside access cycles.** In IDLE and RESP: memWriteEnable=0, memAddr=0, memUnitSize=010, memWriteData=0.
- **Writes.** memWriteEnable is never high in a load cycle.

## Timing
- **Reset values:** state IDLE, reqReady=1, respValid=0, respRData=0, memWriteEnable=0, memAddr=0, memUnitSize=010, memWriteData=0, byte counter 0.
- **Reset mid-operation:** takes effect immediately and abandons the request. Bytes already written stay in memory. No response is produced.
- **Latency, request accepted at edge E0:**
  - Aligned or non-crossing load: memory cycle E0–E1, respValid in cycle E1–E2.
  - Crossing load: two memory cycles, respValid in E2–E3.
  - Aligned store: one write cycle, respValid in E1–E2.
  - Misaligned store of N bytes: N write cycles, respValid in EN–E(N+1).
- **Throughput:** a new request accepted in RESP starts its first memory cycle on the next cycle. No idle bubble is required.
- **Flow control:** reqValid is ignored while reqReady=0. The requester holds the request. There is no back-pressure on the response.
- **Address wrap:** address 0xFFFFFFFE with a word access uses 0xFFFFFFFC, then 0x00000000.

## Test plan
- **Aligned word load.** Word 0x10 = 0x80FF1234; lw 0x10 → one read cycle (memAddr 0x10, memUnitSize 010); respRData 0x80FF1234; respValid 2 cycles after accept.
- **Byte extension.** Same word; lb 0x13 → 0xFFFFFF80. lbu 0x13 → 0x00000080. lhu 0x12 → 0x000080FF.
- **Crossing word load.** Word 0x0C = 0x44332211, word 0x10 = 0x88776655; lw 0x0E → reads 0x0C then 0x10; respRData 0x66554433; respValid 3 cycles after accept. Also lh 0x0F → 0x00005544.
- **Misaligned word store.** sw 0xAABBCCDD to 0x0B → byte writes at 0x0B, 0x0C, 0x0D, 0x0E with data DD, CC, BB, AA and memUnitSize 000. Afterwards word 0x08 = 0xDD??????, word 0x0C = 0x??AABBCC. respValid 5 cycles after accept.
- **Back-to-back.** Aligned sh 0x1234 to 0x20, then lw 0x20 presented during RESP → accepted with no gap; load returns 0x????1234 (bits [31:16] unchanged).
- **Reset mid-store.** rstn low after 2 of 4 byte writes → only bytes 0x0B and 0x0C changed. reqReady=1 and respValid=0 during and after reset; all mem outputs return to reset values.
